// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-lane arbiter in front of a single-port, combinationally read data
//   memory. At most one lane is granted per cycle. When both lanes are
//   eligible they alternate (round-robin on the last granted lane). Each
//   granted access is checked for misalignment, range and admin-key write
//   protection. The lane gets a registered ack one cycle after its grant.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req0/1, we0/1            lane request level and write flag
//   addr0/1, wd0/1           lane byte address and write data
//   ack0/1, err0/1, rd0/1    lane completion pulse, fault flag, read data
//   key_unlock               allows writes to the protected word while high
//   mem_we/addr/wd, mem_rd   data memory port (read data is combinational)
//   conflict_cnt             saturating count of cycles with both lanes eligible
//
// Handshake: a lane raises reqN with we/addr/wd stable and holds it until it
// sees ackN=1. The cycle a lane is granted is the cycle its memory access
// is presented. ackN pulses for exactly the following cycle and errN/rdN are
// valid with it. reqN seen during the ack cycle is ignored, so a lane that
// keeps reqN high starts a fresh request the cycle after ack.
module dmem_arbiter #(
  parameter int MEM_WORDS    = 64,
  parameter int PROTECT_WORD = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wd0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wd1,
  output logic        ack0,
  output logic        err0,
  output logic [31:0] rd0,
  output logic        ack1,
  output logic        err1,
  output logic [31:0] rd1,
  input  logic        key_unlock,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic [15:0] conflict_cnt
);

  localparam logic [29:0] WORDS_W   = 30'(MEM_WORDS);
  localparam logic [29:0] PROTECT_W = 30'(PROTECT_WORD);

  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic [31:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic        last_grant_q, last_grant_d;  // 0 = lane 0, 1 = lane 1

  logic        elig0, elig1, gnt0, gnt1;
  logic        g_we, fault;
  logic [31:0] g_addr, g_wd, g_rd;

  always_comb begin
    // A lane in its ack cycle is not eligible; this enforces one access per
    // lane per two cycles and makes held requests re-arm naturally.
    elig0 = req0 & ~ack0_q;
    elig1 = req1 & ~ack1_q;

    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (elig0 && elig1) begin
      if (last_grant_q) gnt0 = 1'b1;
      else              gnt1 = 1'b1;
    end else begin
      gnt0 = elig0;
      gnt1 = elig1;
    end

    g_we   = gnt1 ? we1   : we0;
    g_addr = gnt1 ? addr1 : addr0;
    g_wd   = gnt1 ? wd1   : wd0;

    fault = (g_addr[1:0] != 2'b00) ||
            (g_addr[31:2] >= WORDS_W) ||
            (g_we && (g_addr[31:2] == PROTECT_W) && !key_unlock);

    // Memory port is quiet unless a clean access is granted outside reset;
    // this also keeps a write presented during reset away from memory.
    mem_we   = 1'b0;
    mem_addr = 32'h0;
    mem_wd   = 32'h0;
    if (!rst && (gnt0 || gnt1) && !fault) begin
      mem_we   = g_we;
      mem_addr = g_addr;
      mem_wd   = g_wd;
    end

    g_rd = (g_we || fault) ? 32'h0 : mem_rd;

    ack0_d = gnt0;
    ack1_d = gnt1;
    err0_d = gnt0 & fault;
    err1_d = gnt1 & fault;
    rd0_d  = gnt0 ? g_rd : rd0_q;
    rd1_d  = gnt1 ? g_rd : rd1_q;

    last_grant_d = last_grant_q;
    if (gnt0)      last_grant_d = 1'b0;
    else if (gnt1) last_grant_d = 1'b1;

    conflict_cnt_d = conflict_cnt_q;
    if (elig0 && elig1 && (conflict_cnt_q != 16'hFFFF))
      conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack0_q         <= 1'b0;
      ack1_q         <= 1'b0;
      err0_q         <= 1'b0;
      err1_q         <= 1'b0;
      rd0_q          <= 32'h0;
      rd1_q          <= 32'h0;
      conflict_cnt_q <= 16'h0;
      last_grant_q   <= 1'b1;  // lane 0 wins the first conflict
    end else begin
      ack0_q         <= ack0_d;
      ack1_q         <= ack1_d;
      err0_q         <= err0_d;
      err1_q         <= err1_d;
      rd0_q          <= rd0_d;
      rd1_q          <= rd1_d;
      conflict_cnt_q <= conflict_cnt_d;
      last_grant_q   <= last_grant_d;
    end
  end

  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign err0         = err0_q;
  assign err1         = err1_q;
  assign rd0          = rd0_q;
  assign rd1          = rd1_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule
